// File: rtl/obi_pkg.sv
// Shared OBI-subset types and widths for the demux and its address decoder.
package obi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_S0  = 2'd1,
    WAIT_S1  = 2'd2,
    WAIT_ERR = 2'd3
  } obi_dmx_state_e;

  typedef enum logic [1:0] {
    SEL_S0   = 2'd0,
    SEL_S1   = 2'd1,
    SEL_NONE = 2'd2
  } obi_sel_e;

endpackage

// File: rtl/obi_addr_decode.sv
// Base/mask window compare for two slave regions; slave 0 wins on overlap.
module obi_addr_decode
  import obi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output obi_sel_e          sel
);

  // Priority window match
  always_comb begin
    if ((addr & S0_MASK) == S0_BASE) begin
      sel = SEL_S0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      sel = SEL_S1;
    end else begin
      sel = SEL_NONE;
    end
  end

endmodule

// File: rtl/obi_demux_1_to_2.sv
// Address-decoded 1-to-2 OBI demux with an internal error responder for unmapped
// accesses; the FSM only remembers which target owes the single outstanding read.
module obi_demux_1_to_2
  import obi_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S0_BASE   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S0_MASK   = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] S1_BASE   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK   = 32'hFFFF_0000,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m_req_i,
  output logic              m_gnt_o,
  input  logic [ADDR_W-1:0] m_addr_i,
  input  logic              m_we_i,
  input  logic [BE_W-1:0]   m_be_i,
  input  logic [DATA_W-1:0] m_wdata_i,
  output logic              m_rvalid_o,
  output logic [DATA_W-1:0] m_rdata_o,
  output logic              s0_req_o,
  input  logic              s0_gnt_i,
  output logic [ADDR_W-1:0] s0_addr_o,
  output logic              s0_we_o,
  output logic [BE_W-1:0]   s0_be_o,
  output logic [DATA_W-1:0] s0_wdata_o,
  input  logic              s0_rvalid_i,
  input  logic [DATA_W-1:0] s0_rdata_i,
  output logic              s1_req_o,
  input  logic              s1_gnt_i,
  output logic [ADDR_W-1:0] s1_addr_o,
  output logic              s1_we_o,
  output logic [BE_W-1:0]   s1_be_o,
  output logic [DATA_W-1:0] s1_wdata_o,
  input  logic              s1_rvalid_i,
  input  logic [DATA_W-1:0] s1_rdata_i,
  output logic              decode_err_o,
  output logic              bad_state_o
);

  obi_sel_e       sel_s;
  obi_dmx_state_e state_r;
  logic           bad_state_r;
  logic           done_s;
  logic           available_s;
  logic           gnt_s;
  logic           accept_rd_s;

  obi_addr_decode #(
    .S0_BASE (S0_BASE),
    .S0_MASK (S0_MASK),
    .S1_BASE (S1_BASE),
    .S1_MASK (S1_MASK)
  ) u_decode (
    .addr (m_addr_i),
    .sel  (sel_s)
  );

  assign s0_addr_o  = m_addr_i;
  assign s0_we_o    = m_we_i;
  assign s0_be_o    = m_be_i;
  assign s0_wdata_o = m_wdata_i;
  assign s1_addr_o  = m_addr_i;
  assign s1_we_o    = m_we_i;
  assign s1_be_o    = m_be_i;
  assign s1_wdata_o = m_wdata_i;

  // Completion of the outstanding read frees the port in the same cycle
  always_comb begin
    done_s = 1'b0;
    case (state_r)
      WAIT_S0:  done_s = s0_rvalid_i;
      WAIT_S1:  done_s = s1_rvalid_i;
      WAIT_ERR: done_s = 1'b1;
      default:  done_s = 1'b0;
    endcase
    available_s = (state_r == IDLE) | done_s;
  end

  // Request routing and grant return; unmapped accesses are granted internally
  always_comb begin
    s0_req_o = m_req_i & available_s & (sel_s == SEL_S0);
    s1_req_o = m_req_i & available_s & (sel_s == SEL_S1);
    case (sel_s)
      SEL_S0:  gnt_s = m_req_i & available_s & s0_gnt_i;
      SEL_S1:  gnt_s = m_req_i & available_s & s1_gnt_i;
      default: gnt_s = m_req_i & available_s;
    endcase
    m_gnt_o      = gnt_s;
    decode_err_o = gnt_s & (sel_s == SEL_NONE);
    accept_rd_s  = gnt_s & ~m_we_i;
  end

  // Response steering from whichever target owns the outstanding read
  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = {DATA_W{1'b0}};
    case (state_r)
      WAIT_S0: begin
        m_rvalid_o = s0_rvalid_i;
        m_rdata_o  = s0_rvalid_i ? s0_rdata_i : {DATA_W{1'b0}};
      end
      WAIT_S1: begin
        m_rvalid_o = s1_rvalid_i;
        m_rdata_o  = s1_rvalid_i ? s1_rdata_i : {DATA_W{1'b0}};
      end
      WAIT_ERR: begin
        m_rvalid_o = 1'b1;
        m_rdata_o  = ERR_RDATA;
      end
      default: begin
        m_rvalid_o = 1'b0;
        m_rdata_o  = {DATA_W{1'b0}};
      end
    endcase
  end

  // Outstanding-target tracking and sticky detection of unsolicited responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      bad_state_r <= 1'b0;
    end else begin
      if (accept_rd_s) begin
        case (sel_s)
          SEL_S0:  state_r <= WAIT_S0;
          SEL_S1:  state_r <= WAIT_S1;
          default: state_r <= WAIT_ERR;
        endcase
      end else if (done_s) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_r;
      end
      if ((s0_rvalid_i && (state_r != WAIT_S0)) || (s1_rvalid_i && (state_r != WAIT_S1))) begin
        bad_state_r <= 1'b1;
      end else begin
        bad_state_r <= bad_state_r;
      end
    end
  end

  assign bad_state_o = bad_state_r;

endmodule

// File: tb/tb_obi_demux_1_to_2.sv
// Directed bench for obi_demux_1_to_2: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_obi_demux_1_to_2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m_req_i, m_gnt_o, m_we_i, m_rvalid_o;
  logic [31:0] m_addr_i, m_wdata_i, m_rdata_o;
  logic [3:0]  m_be_i;
  logic        s0_req_o, s0_gnt_i, s0_we_o, s0_rvalid_i;
  logic [31:0] s0_addr_o, s0_wdata_o, s0_rdata_i;
  logic [3:0]  s0_be_o;
  logic        s1_req_o, s1_gnt_i, s1_we_o, s1_rvalid_i;
  logic [31:0] s1_addr_o, s1_wdata_o, s1_rdata_i;
  logic [3:0]  s1_be_o;
  logic        decode_err_o, bad_state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  obi_demux_1_to_2 dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s0_req_o(s0_req_o), .s0_gnt_i(s0_gnt_i), .s0_addr_o(s0_addr_o), .s0_we_o(s0_we_o),
    .s0_be_o(s0_be_o), .s0_wdata_o(s0_wdata_o), .s0_rvalid_i(s0_rvalid_i), .s0_rdata_i(s0_rdata_i),
    .s1_req_o(s1_req_o), .s1_gnt_i(s1_gnt_i), .s1_addr_o(s1_addr_o), .s1_we_o(s1_we_o),
    .s1_be_o(s1_be_o), .s1_wdata_o(s1_wdata_o), .s1_rvalid_i(s1_rvalid_i), .s1_rdata_i(s1_rdata_i),
    .decode_err_o(decode_err_o), .bad_state_o(bad_state_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m_req_i = 1'b0; m_addr_i = 32'h0; m_we_i = 1'b0; m_be_i = 4'hF; m_wdata_i = 32'h0;
    s0_gnt_i = 1'b0; s0_rvalid_i = 1'b0; s0_rdata_i = 32'h0;
    s1_gnt_i = 1'b0; s1_rvalid_i = 1'b0; s1_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({m_gnt_o, s0_req_o, s1_req_o, m_rvalid_o, decode_err_o, bad_state_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000", {m_gnt_o, s0_req_o, s1_req_o, m_rvalid_o, decode_err_o, bad_state_o});
    end
    checks++;
    if (m_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", m_rdata_o); end
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
  endtask

  task automatic test_s0_read();
    m_req_i = 1'b1; m_addr_i = 32'h0000_0010; m_we_i = 1'b0; s0_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({s0_req_o, s1_req_o, m_gnt_o, decode_err_o} !== 4'b1010) begin
      failures++; $display("FAIL s0rd_addr got=%b want=1010", {s0_req_o, s1_req_o, m_gnt_o, decode_err_o});
    end
    next_cycle();
    m_req_i = 1'b0; s0_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, s0_req_o, s1_req_o} !== 3'b000) begin
      failures++; $display("FAIL s0rd_wait got=%b want=000", {m_rvalid_o, s0_req_o, s1_req_o});
    end
    next_cycle();
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'h1234_5678;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, m_rdata_o} !== {1'b1, 32'h1234_5678}) begin
      failures++; $display("FAIL s0rd_resp got=%b/%h want=1/12345678", m_rvalid_o, m_rdata_o);
    end
    next_cycle();
    s0_rvalid_i = 1'b0; s0_rdata_i = 32'h0;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, bad_state_o, s1_req_o} !== 3'b000) begin
      failures++; $display("FAIL s0rd_after got=%b want=000", {m_rvalid_o, bad_state_o, s1_req_o});
    end
    next_cycle();
  endtask

  task automatic test_s1_write();
    m_req_i = 1'b1; m_addr_i = 32'h8000_0004; m_we_i = 1'b1; m_wdata_i = 32'hA5A5_A5A5;
    m_be_i = 4'b0011; s1_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({m_gnt_o, s1_req_o, s0_req_o} !== 3'b010) begin
        failures++; $display("FAIL s1wr_stall%0d got=%b want=010", i, {m_gnt_o, s1_req_o, s0_req_o});
      end
      next_cycle();
    end
    s1_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_gnt_o, s1_req_o, s1_we_o, s1_be_o, s1_wdata_o, s1_addr_o} !== {3'b111, 4'b0011, 32'hA5A5_A5A5, 32'h8000_0004}) begin
      failures++; $display("FAIL s1wr_grant got=%b%b%b/%b/%h/%h want=111/0011/a5a5a5a5/80000004",
                           m_gnt_o, s1_req_o, s1_we_o, s1_be_o, s1_wdata_o, s1_addr_o);
    end
    next_cycle();
    // Still IDLE: an S0 read without grant is forwarded, and no rvalid is produced
    m_addr_i = 32'h0000_0100; m_we_i = 1'b0; m_be_i = 4'hF; s1_gnt_i = 1'b0; s0_gnt_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s0_req_o, m_gnt_o, m_rvalid_o} !== 3'b100) begin
      failures++; $display("FAIL s1wr_idle got=%b want=100", {s0_req_o, m_gnt_o, m_rvalid_o});
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_unmapped_read();
    m_req_i = 1'b1; m_addr_i = 32'h4000_0000; m_we_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({m_gnt_o, decode_err_o, s0_req_o, s1_req_o} !== 4'b1100) begin
      failures++; $display("FAIL unmap_grant got=%b want=1100", {m_gnt_o, decode_err_o, s0_req_o, s1_req_o});
    end
    next_cycle();
    m_req_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, decode_err_o, m_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL unmap_resp got=%b%b/%h want=10/deadbeef", m_rvalid_o, decode_err_o, m_rdata_o);
    end
    next_cycle();
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, m_rdata_o} !== 33'h0) begin
      failures++; $display("FAIL unmap_after got=%b/%h want=0/0", m_rvalid_o, m_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    m_req_i = 1'b1; m_addr_i = 32'h8000_0100; m_we_i = 1'b0; s1_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_gnt_o, s1_req_o} !== 2'b11) begin
      failures++; $display("FAIL b2b_s1grant got=%b want=11", {m_gnt_o, s1_req_o});
    end
    next_cycle();
    s1_gnt_i = 1'b0; m_addr_i = 32'h0000_0020; s0_gnt_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if ({s0_req_o, m_gnt_o, m_rvalid_o} !== 3'b000) begin
        failures++; $display("FAIL b2b_block%0d got=%b want=000", i, {s0_req_o, m_gnt_o, m_rvalid_o});
      end
      next_cycle();
    end
    s1_rvalid_i = 1'b1; s1_rdata_i = 32'hCAFE_0001;
    @(negedge clk_i);
    checks++;
    if ({s0_req_o, m_gnt_o, m_rvalid_o, m_rdata_o} !== {3'b111, 32'hCAFE_0001}) begin
      failures++; $display("FAIL b2b_handover got=%b%b%b/%h want=111/cafe0001", s0_req_o, m_gnt_o, m_rvalid_o, m_rdata_o);
    end
    next_cycle();
    m_req_i = 1'b0; s0_gnt_i = 1'b0; s1_rvalid_i = 1'b0; s1_rdata_i = 32'h0;
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, m_rdata_o} !== {1'b1, 32'h0BAD_F00D}) begin
      failures++; $display("FAIL b2b_s0resp got=%b/%h want=1/0badf00d", m_rvalid_o, m_rdata_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, bad_state_o} !== 2'b00) begin
      failures++; $display("FAIL b2b_after got=%b want=00", {m_rvalid_o, bad_state_o});
    end
    next_cycle();
  endtask

  task automatic test_spurious_rvalid();
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, bad_state_o, m_rdata_o} !== 34'h0) begin
      failures++; $display("FAIL spur_same got=%b%b/%h want=00/0", m_rvalid_o, bad_state_o, m_rdata_o);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (bad_state_o !== 1'b1) begin failures++; $display("FAIL spur_flag got=%b want=1", bad_state_o); end
    repeat (10) next_cycle();
    @(negedge clk_i);
    checks++;
    if (bad_state_o !== 1'b1) begin failures++; $display("FAIL spur_sticky got=%b want=1", bad_state_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    m_req_i = 1'b1; m_addr_i = 32'h8000_0008; m_we_i = 1'b0; s1_gnt_i = 1'b1;
    next_cycle();
    idle_inputs();
    rst_ni = 1'b0;
    s1_rvalid_i = 1'b1; s1_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, bad_state_o, m_rdata_o} !== 34'h0) begin
      failures++; $display("FAIL rstmid_idle got=%b%b/%h want=00/0", m_rvalid_o, bad_state_o, m_rdata_o);
    end
    s1_rvalid_i = 1'b0; s1_rdata_i = 32'h0;
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    s1_rvalid_i = 1'b1; s1_rdata_i = 32'h7777_7777;
    @(negedge clk_i);
    checks++;
    if ({m_rvalid_o, bad_state_o} !== 2'b00) begin
      failures++; $display("FAIL rstmid_late got=%b want=00", {m_rvalid_o, bad_state_o});
    end
    next_cycle();
    idle_inputs();
    @(negedge clk_i);
    checks++;
    if (bad_state_o !== 1'b1) begin failures++; $display("FAIL rstmid_flag got=%b want=1", bad_state_o); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_s0_read();
    test_s1_write();
    test_unmapped_read();
    test_back_to_back();
    test_spurious_rvalid();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_demux_1_to_2.md
Name: obi_demux_1_to_2

Overview:
Address-decoded 1-to-2 OBI demux: one OBI master fans out to two OBI slave windows, using the team's OBI subset (req/gnt/addr/we/be/wdata/rvalid/rdata; writes complete at grant, reads return exactly one rvalid). It is the counterpart to the 2-to-1 master mux and sits between a core or mux output and two slave regions (e.g. SRAM, peripherals). At most one read is outstanding at a time. Unmapped accesses are absorbed by an internal error responder.

Parameters:
S0_BASE, 32'h0000_0000, slave 0 window base
S0_MASK, 32'hFFFF_0000, slave 0 match mask: hit when (addr & S0_MASK) == S0_BASE
S1_BASE, 32'h8000_0000, slave 1 window base
S1_MASK, 32'hFFFF_0000, slave 1 match mask
ERR_RDATA, 32'hDEAD_BEEF, read data returned for unmapped reads

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset; asynchronous, active-low
m_req_i / m_gnt_o  in/out  1/1  master request / grant
m_addr_i, m_wdata_i  in  32 each  master address, write data
m_we_i, m_be_i  in  1, 4  master write enable, byte enables
m_rvalid_o, m_rdata_o  out  1, 32  master read response
s0_req_o, s0_gnt_i  out/in  1/1  slave 0 request / grant
s0_addr_o, s0_we_o, s0_be_o, s0_wdata_o  out  32,1,4,32  slave 0 address phase
s0_rvalid_i, s0_rdata_i  in  1, 32  slave 0 response
s1_*  same as s0_*  slave 1
decode_err_o  out  1  one-cycle pulse when an unmapped access is granted
bad_state_o  out  1  sticky protocol-violation flag

Behaviour:
- Decode is combinational: sel = S0 if S0 hits, else S1 if S1 hits, else NONE. S0 wins on overlap.
- FSM states: IDLE, WAIT_S0, WAIT_S1, WAIT_ERR. Async reset forces IDLE and clears bad_state_o.
- done = (WAIT_S0 & s0_rvalid_i) | (WAIT_S1 & s1_rvalid_i) | WAIT_ERR.
- available = IDLE | done. A new request may be granted in the same cycle as the previous read's rvalid.
- Address phase:
  - s0_addr/we/be/wdata_o mirror the master unconditionally; s1_* likewise.
  - sX_req_o = m_req_i & available & (sel == SX).
  - m_gnt_o = m_req_i & available & (sel==S0 ? s0_gnt_i : sel==S1 ? s1_gnt_i : 1).
- Transitions on posedge:
  - read accepted (m_req_i & m_gnt_o & ~m_we_i) -> WAIT_S0 / WAIT_S1 / WAIT_ERR per sel.
  - otherwise, if done -> IDLE; else hold.
  - Accepted writes do not change state. Unmapped writes are dropped.
- Response phase:
  - WAIT_S0: m_rvalid_o = s0_rvalid_i; m_rdata_o = s0_rvalid_i ? s0_rdata_i : 0.
  - WAIT_S1: same with s1.
  - WAIT_ERR: m_rvalid_o = 1, m_rdata_o = ERR_RDATA, exactly one cycle after grant.
  - IDLE: m_rvalid_o = 0, m_rdata_o = 0.
- decode_err_o = m_req_i & m_gnt_o & (sel == NONE), combinational.
- bad_state_o is set on the clock edge when s0_rvalid_i is seen outside WAIT_S0, or s1_rvalid_i outside WAIT_S1. It is cleared only by reset.
- Reset values: state IDLE, bad_state_o 0. With m_req_i = 0, all req/gnt/rvalid/rdata/decode_err outputs are 0.
- Reset mid-read: state returns to IDLE immediately. A late slave rvalid after reset is flagged via bad_state_o.
- Latency: zero added cycles in either phase (purely combinational paths); the FSM only tracks the outstanding target.

Decomposition:
- obi_pkg: typedef enum obi_dmx_state_e {IDLE, WAIT_S0, WAIT_S1, WAIT_ERR}; typedef enum obi_sel_e {SEL_S0, SEL_S1, SEL_NONE}; OBI width constants (ADDR_W = 32, DATA_W = 32, BE_W = 4).
- Sub-module obi_addr_decode: parameterised base/mask compare producing obi_sel_e. Reused by future N-way demuxes.

Test Plan:
- Read 0x0000_0010 with s0_gnt_i = 1; s0 returns rvalid two cycles later with 0x1234_5678 -> s0_req_o = 1 only, m_gnt_o = 1; m_rvalid_o = 1, m_rdata_o = 0x1234_5678 in the s0 rvalid cycle; s1_req_o stays 0.
- Write 0x8000_0004 with data 0xA5A5_A5A5, be 4'b0011, s1_gnt_i held 0 for 3 cycles then 1 -> m_gnt_o low 3 cycles then high; s1_wdata_o = 0xA5A5_A5A5; state stays IDLE.
- Read 0x4000_0000 (unmapped) -> m_gnt_o = 1 same cycle, decode_err_o pulses; next cycle m_rvalid_o = 1, m_rdata_o = 0xDEAD_BEEF; no sX_req_o.
- Back-to-back: S1 read outstanding, new S0 read presented -> s0_req_o held 0 until the s1_rvalid_i cycle, then s0_req_o = 1 and is granted in that same cycle.
- Spurious s0_rvalid_i = 1 while IDLE -> m_rvalid_o = 0; bad_state_o = 1 from the next cycle, still 1 after 10 cycles.
- rst_ni low during WAIT_S1 -> state IDLE immediately, m_rvalid_o = 0; a subsequent s1_rvalid_i sets bad_state_o.
